dmem_line_model: RTL

Fixed-latency, line-wide data memory that sits directly downstream of the data cache. It serves one 256-bit line read or write per request and returns a single-cycle acknowledge after a configurable delay. It is the memory side of the cache refill/write-back handshake: enable/write/address/data in, data plus ack out. It is used both as the simulation memory and as the synthesizable model for latency studies.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_line_array.sv | 45 ++++
 rtl/dmem_line_model.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the line-wide data memory model.
`default_nettype none

package dmem_pkg;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;
    localparam int ADDR_W   = 32;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_line_array.sv
// ============================================================================
// Module  : dmem_line_array
// Brief   : DEPTH x 256-bit single-port line storage, registered read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    // Contents deliberately have no reset; only the read register does.
    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_line_model.sv
// ============================================================================
// Module  : dmem_line_model
// Brief   : Fixed-latency 256-bit line memory behind the data cache.
//           Optional protocol checker enabled by DMEM_PROTOCOL_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_line_model
    import dmem_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_enable_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_ack_o,
    output logic              err_o
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LADR_W = ADDR_W - OFFSET_W;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                wr_q;
    logic [LADR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   data_q;
    logic                ack_q;

    logic                w_fire;
    logic                w_we;
    logic                w_re;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mem_enable_i) begin
                        wr_q    <= mem_write_i;
                        addr_q  <= mem_addr_i[ADDR_W-1:OFFSET_W];
                        data_q  <= mem_data_i;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_ACK: begin
                    // Ack is registered, so it is visible for the cycle after ACK.
                    ack_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign w_fire = (state_q == ST_BUSY) && (cnt_q == '0);
    assign w_we   = w_fire && wr_q;
    assign w_re   = w_fire && !wr_q;

    dmem_line_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (w_we),
        .re_i    (w_re),
        .idx_i   (addr_q[IDX_W-1:0]),
        .wdata_i (data_q),
        .rdata_o (mem_data_o)
    );

    assign mem_ack_o = ack_q;

`ifdef DMEM_PROTOCOL_CHECK_EN
    logic err_q;
    logic w_mismatch;

    assign w_mismatch = (state_q == ST_BUSY) &&
                        (!mem_enable_i ||
                         (mem_write_i != wr_q) ||
                         (mem_addr_i[ADDR_W-1:OFFSET_W] != addr_q) ||
                         (wr_q && (mem_data_i != data_q)));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else if (w_mismatch) begin
            err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_i && w_mismatch) begin
            $error("dmem_line_model: request changed while %s, addr=%h",
                   state_q.name(), mem_addr_i);
        end
    end
`endif

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // Offset bits and aliased upper line bits never index the array.
    logic unused_bits;
    assign unused_bits = ^{mem_addr_i[OFFSET_W-1:0], addr_q[LADR_W-1:IDX_W]};

endmodule

`default_nettype wire
